// File: rtl/cim_act_driver_if.sv
// Activation handshake plus array-side drive signals of the CIM input driver.
// master = upstream/array side, slave = the driver itself.
interface cim_act_driver_if #(
  parameter int unsigned N_ROW = 16,
  parameter int unsigned ACT_W = 4
);
  localparam int unsigned BitW = (ACT_W > 1) ? $clog2(ACT_W) : 1;
  localparam int unsigned CntW = $clog2(N_ROW + 1);

  logic                     act_valid;
  logic                     act_ready;
  logic [N_ROW*ACT_W-1:0]   act_data;
  logic [N_ROW-1:0]         act_mask;
  logic [N_ROW-1:0]         wl;
  logic [CntW-1:0]          matrix_act;
  logic [BitW-1:0]          bit_idx;
  logic                     col_en;
  logic                     done;

  modport master (
    output act_valid, act_data, act_mask,
    input  act_ready, wl, matrix_act, bit_idx, col_en, done
  );

  modport slave (
    input  act_valid, act_data, act_mask,
    output act_ready, wl, matrix_act, bit_idx, col_en, done
  );
endinterface

// File: rtl/cim_act_driver.sv
// Bit-serial (LSB first) word-line driver for the CIM macro: one col_en strobe per
// bit-plane, matrix_act held from acceptance to next acceptance for the quantizer.
module cim_act_driver #(
  parameter int unsigned N_ROW  = 16,
  parameter int unsigned ACT_W  = 4,
  parameter int unsigned SETTLE = 2
) (
  input logic             clk,
  input logic             rst_n,
  cim_act_driver_if.slave bus
);
  localparam int unsigned BitW = (ACT_W > 1) ? $clog2(ACT_W) : 1;
  localparam int unsigned CntW = $clog2(N_ROW + 1);
  localparam logic [3:0]      SettleLast = 4'(SETTLE - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(ACT_W - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [N_ROW*ACT_W-1:0] act_q, act_d;
  logic [N_ROW-1:0]       mask_q, mask_d;
  logic [CntW-1:0]        ma_q, ma_d;
  logic [N_ROW-1:0]       wl_q, wl_d;
  logic                   col_en_q, col_en_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [CntW-1:0]        pop;
  logic [N_ROW-1:0]       plane;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N_ROW); i++) begin
      pop = pop + CntW'(bus.act_mask[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    act_d   = act_q;
    mask_d  = mask_q;
    ma_d    = ma_q;
    unique case (state_q)
      StIdle: begin
        if (bus.act_valid) begin
          act_d   = bus.act_data;
          mask_d  = bus.act_mask;
          ma_d    = pop;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = (|bus.act_mask) ? StDrive : StDone;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (bit_q != BitLast) begin
          bit_d   = bit_q + 1'b1;
          cnt_d   = '0;
          state_d = StDrive;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    plane = '0;
    for (int i = 0; i < int'(N_ROW); i++) begin
      plane[i] = mask_d[i] & act_d[i*ACT_W + int'(bit_d)];
    end
    wl_d     = (state_d == StDrive || state_d == StSample) ? plane : '0;
    col_en_d = (state_d == StSample);
    done_d   = (state_d == StDone);
    ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      act_q    <= '0;
      mask_q   <= '0;
      ma_q     <= '0;
      wl_q     <= '0;
      col_en_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      act_q    <= act_d;
      mask_q   <= mask_d;
      ma_q     <= ma_d;
      wl_q     <= wl_d;
      col_en_q <= col_en_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.act_ready  = ready_q;
  assign bus.wl         = wl_q;
  assign bus.matrix_act = ma_q;
  assign bus.bit_idx    = bit_q;
  assign bus.col_en     = col_en_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_cim_act_driver.sv
// Directed bench for cim_act_driver: reset, full/partial/zero masks, back-to-back
// acceptance and asynchronous reset mid-vector, all with hand-computed expectations.
module tb_cim_act_driver;
  localparam int unsigned SETTLE = 2;
  localparam int P    = SETTLE + 1;
  localparam int LAST = 4 * P;

  localparam logic [63:0] DataA   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] DataIdx = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cim_act_driver_if #(.N_ROW(16), .ACT_W(4)) bus ();

  cim_act_driver #(.N_ROW(16), .ACT_W(4), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered in a cycle where act_ready should be 1 (cycle 0); returns in cycle 14.
  task automatic run_vec(input logic [63:0] data, input logic [15:0] mask,
                         input logic [4:0] exp_ma,
                         input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3,
                         input bit hold, input logic [63:0] nxt_data,
                         input logic [15:0] nxt_mask);
    logic [15:0] pl [4];
    pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
    bus.act_valid = 1'b1;
    bus.act_data  = data;
    bus.act_mask  = mask;
    check_eq("ready c0", 64'(bus.act_ready), 64'd1);
    for (int c = 1; c <= LAST + 2; c++) begin
      int b;
      @(posedge clk); #1;
      b = (c - 1) / P;
      if (c == 1) begin
        if (hold) begin
          bus.act_data = nxt_data;
          bus.act_mask = nxt_mask;
        end else begin
          bus.act_valid = 1'b0;
        end
      end
      check_eq($sformatf("col_en c%0d", c), 64'(bus.col_en),
               64'((c % P == 0) && (c <= LAST)));
      check_eq($sformatf("done c%0d", c), 64'(bus.done), 64'(c == LAST + 1));
      check_eq($sformatf("ready c%0d", c), 64'(bus.act_ready), 64'(c == LAST + 2));
      check_eq($sformatf("matrix_act c%0d", c), 64'(bus.matrix_act), 64'(exp_ma));
      if (c <= LAST) begin
        check_eq($sformatf("wl c%0d", c), 64'(bus.wl), 64'(pl[b]));
        check_eq($sformatf("bit_idx c%0d", c), 64'(bus.bit_idx), 64'(b));
      end else begin
        check_eq($sformatf("wl idle c%0d", c), 64'(bus.wl), 64'd0);
      end
    end
  endtask

  initial begin
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.act_mask  = '0;
    #12;
    check_eq("rst ready", 64'(bus.act_ready), 64'd1);
    check_eq("rst wl", 64'(bus.wl), 64'd0);
    check_eq("rst col_en", 64'(bus.col_en), 64'd0);
    check_eq("rst done", 64'(bus.done), 64'd0);
    check_eq("rst matrix_act", 64'(bus.matrix_act), 64'd0);
    check_eq("rst bit_idx", 64'(bus.bit_idx), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full mask, every activation 1010b: planes 0/2 empty, 1/3 full.
    run_vec(DataA, 16'hFFFF, 5'd16, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, '0, '0);
    // Partial mask, activation = row index, rows 0..8 enabled.
    run_vec(DataIdx, 16'h01FF, 5'd9, 16'h00AA, 16'h00CC, 16'h00F0, 16'h0100, 1'b0, '0, '0);

    // Zero mask: immediate done, no strobe.
    bus.act_valid = 1'b1;
    bus.act_data  = DataA;
    bus.act_mask  = 16'h0000;
    @(posedge clk); #1;
    bus.act_valid = 1'b0;
    check_eq("zero done c1", 64'(bus.done), 64'd1);
    check_eq("zero col_en c1", 64'(bus.col_en), 64'd0);
    check_eq("zero wl c1", 64'(bus.wl), 64'd0);
    check_eq("zero ready c1", 64'(bus.act_ready), 64'd0);
    check_eq("zero matrix_act c1", 64'(bus.matrix_act), 64'd0);
    @(posedge clk); #1;
    check_eq("zero ready c2", 64'(bus.act_ready), 64'd1);
    check_eq("zero done c2", 64'(bus.done), 64'd0);
    check_eq("zero col_en c2", 64'(bus.col_en), 64'd0);

    // Back-to-back: valid held high, second vector accepted in cycle 14.
    run_vec(DataIdx, 16'h01FF, 5'd9, 16'h00AA, 16'h00CC, 16'h00F0, 16'h0100,
            1'b1, DataA, 16'hFFFF);
    run_vec(DataA, 16'hFFFF, 5'd16, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, '0, '0);

    // Reset asserted during cycle 7 (plane 2 being driven).
    bus.act_valid = 1'b1;
    bus.act_data  = DataIdx;
    bus.act_mask  = 16'h01FF;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      bus.act_valid = 1'b0;
    end
    check_eq("mid wl c7", 64'(bus.wl), 64'h00F0);
    rst_n = 1'b0;
    #1;
    check_eq("mid rst wl", 64'(bus.wl), 64'd0);
    check_eq("mid rst col_en", 64'(bus.col_en), 64'd0);
    check_eq("mid rst matrix_act", 64'(bus.matrix_act), 64'd0);
    check_eq("mid rst ready", 64'(bus.act_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("mid rst no done %0d", k), 64'(bus.done), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post rst done", 64'(bus.done), 64'd0);
    run_vec(DataIdx, 16'h01FF, 5'd9, 16'h00AA, 16'h00CC, 16'h00F0, 16'h0100, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
